// File: rtl/reg_dump_reader.sv
// Debug engine that walks a register-bank range via a read select and streams each word out over valid/ready.
// Define REG_DUMP_PARITY_EN to add the out_par even-parity output registered alongside out_data.
module reg_dump_reader #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clkin,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] first_sel,
  input  logic [AW-1:0] last_sel,
  output logic [AW-1:0] rd_sel,
  input  logic [DW-1:0] rd_data,
  output logic          hold,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [AW-1:0] out_idx,
  output logic          busy,
  output logic          done,
`ifdef REG_DUMP_PARITY_EN
  output logic          out_par,
`endif
  output logic          err
);

  typedef enum logic [1:0] {IDLE, SEL, VALID, DONE} state_t;

  state_t        state_reg;
  logic [AW-1:0] cur_reg;
  logic [AW-1:0] last_reg;

  always_ff @(posedge clkin or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      cur_reg   <= '0;
      last_reg  <= '0;
      rd_sel    <= '0;
      hold      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef REG_DUMP_PARITY_EN
      out_par   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (first_sel <= last_sel) begin
              last_reg  <= last_sel;
              cur_reg   <= first_sel;
              rd_sel    <= first_sel;
              hold      <= 1'b1;
              state_reg <= SEL;
            end else begin
              err <= 1'b1;
            end
          end
        end
        SEL: begin
          // rd_sel has been stable for a full cycle, so the bank bus is settled
          out_data  <= rd_data;
          out_idx   <= cur_reg;
          out_valid <= 1'b1;
`ifdef REG_DUMP_PARITY_EN
          out_par   <= ^rd_data;
`endif
          state_reg <= VALID;
        end
        VALID: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            // Compare before incrementing so a range ending at the top index cannot wrap
            if (cur_reg == last_reg) begin
              done      <= 1'b1;
              state_reg <= DONE;
            end else begin
              cur_reg   <= cur_reg + AW'(1);
              rd_sel    <= cur_reg + AW'(1);
              state_reg <= SEL;
            end
          end
        end
        DONE: begin
          hold      <= 1'b0;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_reg_dump_reader.sv
// Directed bench for reg_dump_reader: bank model on the read port, transfer scoreboard and latency checks.
// With REG_DUMP_PARITY_EN defined it also checks out_par.
module tb_reg_dump_reader;

  logic        clkin;
  logic        reset;
  logic        start;
  logic [4:0]  first_sel;
  logic [4:0]  last_sel;
  logic [4:0]  rd_sel;
  logic [31:0] rd_data;
  logic        hold;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;
`ifdef REG_DUMP_PARITY_EN
  logic        out_par;
`endif

  logic [31:0] bank [32];
  int          n_checks;
  int          n_pass;

  assign rd_data = bank[rd_sel];

  reg_dump_reader #(.AW(5), .DW(32)) dut (
    .clkin     (clkin),
    .reset     (reset),
    .start     (start),
    .first_sel (first_sel),
    .last_sel  (last_sel),
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
    .hold      (hold),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
`ifdef REG_DUMP_PARITY_EN
    .out_par   (out_par),
`endif
    .err       (err)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Runs one dump; stall = cycles out_ready is held low per word, poke = issue a stray start mid-dump.
  task automatic run_dump(input logic [4:0] f, input logic [4:0] l, input int stall,
                          input int exp_cycles, input bit poke);
    int          cyc;
    int          words;
    int          wait_cnt;
    logic [4:0]  exp_idx;
    logic        got_done;
    logic [31:0] held_d;
    logic [4:0]  held_i;
    cyc = 0; words = 0; wait_cnt = 0; exp_idx = f; got_done = 1'b0;
    held_d = '0; held_i = '0;
    @(negedge clkin);
    first_sel = f; last_sel = l; start = 1'b1; out_ready = (stall == 0);
    @(posedge clkin);
    #1 start = 1'b0;
    while (!got_done && cyc < 200) begin
      @(negedge clkin);
      cyc++;
      start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; first_sel = 5'd20; last_sel = 5'd2;
      end
      check_value("err_quiet", 32'(err), 32'd0);
      check_value("hold_high", 32'(hold), 32'd1);
      if (done) begin
        got_done = 1'b1;
        check_value("done_latency", 32'(cyc), 32'(exp_cycles));
        check_value("word_count", 32'(words), 32'(int'(l) - int'(f) + 1));
        check_value("done_valid_low", 32'(out_valid), 32'd0);
      end else if (out_valid) begin
        if (wait_cnt == 0) begin
          held_d = out_data; held_i = out_idx;
        end else begin
          check_value("stall_data", out_data, held_d);
          check_value("stall_idx", 32'(out_idx), 32'(held_i));
        end
        if (wait_cnt >= stall) begin
          out_ready = 1'b1;
          check_value("xfer_idx", 32'(out_idx), 32'(exp_idx));
          check_value("xfer_data", out_data, bank[exp_idx]);
`ifdef REG_DUMP_PARITY_EN
          check_value("xfer_par", 32'(out_par), 32'(^bank[exp_idx]));
`endif
          $display("xfer idx=%0d data=%h", out_idx, out_data);
          exp_idx  = exp_idx + 5'd1;
          words++;
          wait_cnt = 0;
        end else begin
          out_ready = 1'b0;
          wait_cnt++;
        end
      end else begin
        out_ready = (stall == 0);
      end
    end
    check_value("done_seen", 32'(got_done), 32'd1);
    @(negedge clkin);
    check_value("after_done_pulse", 32'(done), 32'd0);
    check_value("after_hold", 32'(hold), 32'd0);
    check_value("after_busy", 32'(busy), 32'd0);
    check_value("after_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0;
    for (int i = 0; i < 32; i++) bank[i] = 32'h1000_0000 + 32'(i);
    bank[1] = 32'h11; bank[2] = 32'h22; bank[3] = 32'h33; bank[4] = 32'h44;
    bank[31] = 32'hDEADBEEF;
    reset = 1'b0; start = 1'b0; first_sel = '0; last_sel = '0; out_ready = 1'b0;
    #12;
    check_value("rst_rd_sel", 32'(rd_sel), 32'd0);
    check_value("rst_hold", 32'(hold), 32'd0);
    check_value("rst_valid", 32'(out_valid), 32'd0);
    check_value("rst_data", out_data, 32'd0);
    check_value("rst_idx", 32'(out_idx), 32'd0);
    check_value("rst_busy", 32'(busy), 32'd0);
    check_value("rst_done", 32'(done), 32'd0);
    check_value("rst_err", 32'(err), 32'd0);
    @(negedge clkin) reset = 1'b1;

    // Basic 1..4, ready high: done 9 cycles after start
    run_dump(5'd1, 5'd4, 0, 9, 1'b0);
    // Same range, 3 stall cycles per word: 5 cycles per word
    run_dump(5'd1, 5'd4, 3, 21, 1'b0);
    // Single top register, no wrap
    run_dump(5'd31, 5'd31, 0, 3, 1'b0);
    // Stray start during busy is ignored
    run_dump(5'd1, 5'd4, 0, 9, 1'b1);

    // Rejected range
    @(negedge clkin);
    first_sel = 5'd5; last_sel = 5'd2; start = 1'b1;
    @(posedge clkin);
    #1 start = 1'b0;
    check_value("err_pulse", 32'(err), 32'd1);
    check_value("err_busy", 32'(busy), 32'd0);
    check_value("err_hold", 32'(hold), 32'd0);
    check_value("err_valid", 32'(out_valid), 32'd0);
    @(posedge clkin);
    #1 check_value("err_one_cycle", 32'(err), 32'd0);
    check_value("err_stay_idle", 32'(busy), 32'd0);

    // Reset during VALID of word 2
    @(negedge clkin);
    first_sel = 5'd1; last_sel = 5'd4; start = 1'b1; out_ready = 1'b1;
    @(posedge clkin);
    #1 start = 1'b0;
    repeat (3) @(negedge clkin);
    @(negedge clkin);
    check_value("mid_valid", 32'(out_valid), 32'd1);
    check_value("mid_idx", 32'(out_idx), 32'd2);
    out_ready = 1'b0;
    reset = 1'b0;
    #1;
    check_value("async_valid", 32'(out_valid), 32'd0);
    check_value("async_hold", 32'(hold), 32'd0);
    check_value("async_busy", 32'(busy), 32'd0);
    check_value("async_rd_sel", 32'(rd_sel), 32'd0);
    check_value("async_data", out_data, 32'd0);
    check_value("async_idx", 32'(out_idx), 32'd0);
    repeat (2) begin
      @(negedge clkin);
      check_value("rst_no_done", 32'(done), 32'd0);
    end
    reset = 1'b1;
    bank[0] = 32'hA5A5_0F0F;
    run_dump(5'd0, 5'd0, 0, 3, 1'b0);

`ifdef REG_DUMP_PARITY_EN
    bank[3] = 32'h0000_0007;
    run_dump(5'd3, 5'd3, 0, 3, 1'b0);
    bank[3] = 32'h0000_0003;
    run_dump(5'd3, 5'd3, 0, 3, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Debug read-out engine that walks a contiguous range of the CPU register bank through one of the bank's combinational read-select ports and streams each captured word out over a valid/ready interface. It sits beside the register bank, driving a read select (busAsel or busBsel via the debug mux) and sampling the corresponding bus. While a dump is running it freezes architectural writes by asserting `hold`, which the top level ANDs into the bank's write enable, so the dumped image is self-consistent.

## Interface
Parameters:
- `AW`, default 5, register select width (bank depth 2^AW).
- `DW`, default 32, register data width.

Ports:
- `clkin`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a dump; sampled only in IDLE.
- `first_sel`  in  AW  first register index, sampled with `start`.
- `last_sel`  in  AW  last register index (inclusive), sampled with `start`.
- `rd_sel`  out  AW  registered select driven to the bank read port.
- `rd_data`  in  DW  bank read bus for `rd_sel`; combinational in the bank.
- `hold`  out  1  freeze request for bank writes.
- `out_valid`  out  1  output word available.
- `out_ready`  in  1  sink accepts the word.
- `out_data`  out  DW  captured register value.
- `out_idx`  out  AW  index of `out_data`.
- `busy`  out  1  dump in progress (not IDLE).
- `done`  out  1  one-cycle pulse after the last word transfers.
- `err`  out  1  one-cycle pulse on a rejected `start`.

## Operation
- States: IDLE, SEL, VALID, DONE.
- IDLE: `start`=1 and `first_sel`<=`last_sel` -> latch bounds, `cur`<=`first_sel`, `rd_sel`<=`first_sel`, `hold`<=1 -> SEL. `start`=1 and `first_sel`>`last_sel` -> `err` pulses for 1 cycle, stay IDLE.
- SEL, one cycle: `rd_sel` is stable at `cur`. On exit, `out_data`<=`rd_data`, `out_idx`<=`cur`, `out_valid`<=1 -> VALID.
- VALID: hold `out_data`/`out_idx` stable until `out_valid`&&`out_ready` at a rising edge. On that transfer, `out_valid`<=0. If `cur`==`last_sel` -> DONE. Otherwise `cur`<=`cur`+1, `rd_sel`<=`cur`+1 -> SEL.
- DONE: `done`=1 for exactly one cycle, `hold`<=0 -> IDLE.
- The end test compares `cur` against `last_sel` before incrementing, so `last_sel`=2^AW-1 never wraps the counter. A single-register range (`first_sel`==`last_sel`) produces exactly one word.
- `start` outside IDLE is ignored and does not assert `err`.
- Register 0 is dumped like any other index; its value is whatever the bank returns.
- `busy`=1 in SEL, VALID, and DONE.

## Timing
- Reset values: `rd_sel`=0, `hold`=0, `out_valid`=0, `out_data`=0, `out_idx`=0, `busy`=0, `done`=0, `err`=0, state IDLE.
- `reset` low at any point, including mid-dump, returns all outputs to their reset values immediately. The in-flight word is dropped and no `done` is produced.
- `start` sampled at edge N -> `hold`=1 and `rd_sel`=`first_sel` in cycle N+1, `out_valid`=1 in cycle N+2.
- Per-word cost with `out_ready` tied high: 2 cycles (SEL + VALID). A range of k words takes 2k+1 cycles from the `start` edge to the `done` pulse.
- `out_valid` never deasserts without a transfer. `out_ready` may toggle freely.
- `hold` rises the cycle after `start` is accepted and falls the cycle after `done`.

## Configuration
- `REG_DUMP_PARITY_EN` defined: adds output `out_par` (1 bit) = even parity (XOR-reduce) of `out_data`. It is registered alongside `out_data`, has reset value 0, and is valid whenever `out_valid`=1.
- `REG_DUMP_PARITY_EN` undefined: the `out_par` port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then `start` with `first_sel`=1, `last_sel`=4, bank loaded with 0x11,0x22,0x33,0x44 at r1..r4, `out_ready`=1 -> four transfers (idx 1..4, data 0x11..0x44), `done` 9 cycles after the `start` edge, `hold` high throughout.
- Same range with `out_ready` low for 3 cycles on every word -> `out_data`/`out_idx` stable while stalled, same four words in order, no duplicates.
- `first_sel`=`last_sel`=31, r31=0xDEADBEEF -> exactly one word (idx 31, 0xDEADBEEF), then `done`; `cur` never wraps to 0.
- `start` with `first_sel`=5, `last_sel`=2 -> `err` one-cycle pulse, `busy`/`hold`/`out_valid` stay 0. A second `start` issued while a dump is busy is ignored.
- Assert `reset` low during VALID of word 2 in a 1..4 dump -> all outputs 0 asynchronously. After release, a new dump of 0..0 completes normally.
- With `REG_DUMP_PARITY_EN`: r3=0x00000007 -> `out_par`=1; r3=0x00000003 -> `out_par`=0.
